// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin sharing of one APB master port between NUM_REQ
// requesters. Each requester issues single read/write commands over a
// valid/ready handshake. The block runs APB SETUP/ACCESS on the shared bus and
// returns read data and an error flag per command. An ACCESS watchdog aborts
// transfers to a slave that never raises pready.
module apb_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               pclk,
  input  logic                               presetn,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
  output logic                               rsp_err,
  output logic [APB_ADDR_WIDTH-1:0]          paddr,
  output logic                               pwrite,
  output logic [APB_DATA_WIDTH-1:0]          pwdata,
  output logic                               psel,
  output logic                               penable,
  input  logic [APB_DATA_WIDTH-1:0]          prdata,
  input  logic                               pready,
  input  logic                               pslverr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Last wait-counter value before an abort: the abort fires in the ACCESS
  // cycle that would bring the count of stalled cycles up to TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cur_idx;
  logic            any_valid;
  logic [CW-1:0]   wait_cnt;
  logic            timeout_hit;
  logic            done;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (wait_cnt == TO_LAST);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int cand;
    cand      = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand[IW-1:0];
      end
    end
  end

  // Next-state logic, one-hot accept strobe and the completion flag.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          state_nxt         = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready || timeout_hit) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winning command; bus payload then holds until the next accept.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      cur_idx    <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else if (state == IDLE && any_valid) begin
      paddr      <= req_addr[int'(winner)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      pwrite     <= req_write[winner];
      pwdata     <= req_wdata[int'(winner)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      cur_idx    <= winner;
      last_grant <= winner;
    end
  end

  // Registered APB phase strobes, derived from the state being entered.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      psel    <= (state_nxt != IDLE);
      penable <= (state_nxt == ACCESS);
    end
  end

  // Count stalled ACCESS cycles; restart whenever a new transfer enters SETUP.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if (state_nxt == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready && TIMEOUT_CYCLES != 0) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // One-cycle completion pulse to the owner with read data and error status.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done ? (NUM_REQ'(1) << cur_idx) : '0;
      rsp_rdata <= (done && pready && !pwrite) ? prdata : '0;
      rsp_err   <= done && (pready ? pslverr : 1'b1);
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed bench for apb_master_arb with a response
// scoreboard. Expected responses are queued when a command is accepted and
// compared when rsp_valid pulses.
module tb_apb_master_arb;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              pclk = 1'b0;
  logic              presetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     paddr;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic              psel;
  logic              penable;
  logic [DW-1:0]     prdata;
  logic [DW-1:0]     prdata_drv;
  logic              pready;
  logic              pslverr;
  logic              slave_auto;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  // In auto mode the slave answers with data derived from the address.
  assign prdata = slave_auto ? (paddr ^ 32'hC0DE_0000) : prdata_drv;

  apb_master_arb #(
    .NUM_REQ       (NR),
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  // Free-running 10 ns clock.
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge pclk) begin : monitor
    exp_t e;
    if (presetn === 1'b1 && rsp_valid !== '0) begin
      if (expq.size() == 0) begin
        checkOutput("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("sb_idx",   64'(rsp_valid), 64'(NR'(1) << e.idx));
        checkOutput("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
        checkOutput("sb_err",   64'(rsp_err),   64'(e.err));
      end
    end
  end

  // One full command from an IDLE cycle through its response pulse.
  // waits = stalled ACCESS cycles before pready; with timeout set pready never rises.
  task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits,
                               input logic [31:0] rdata, input logic slverr,
                               input logic timeout);
    exp_t          e;
    logic [NR-1:0] oh;
    oh = NR'(1) << idx;
    req_write[idx]             = wr;
    req_addr[idx*AW +: AW]     = addr;
    req_wdata[idx*DW +: DW]    = wdata;
    req_valid[idx]             = 1'b1;
    #1;
    checkOutput("accept_ready", 64'(req_ready), 64'(oh));
    checkOutput("idle_psel",    64'(psel),      64'd0);
    e.idx   = idx;
    e.rdata = (wr || timeout) ? 32'd0 : rdata;
    e.err   = timeout | slverr;
    expq.push_back(e);
    @(posedge pclk); #1;
    req_valid[idx] = 1'b0;
    @(negedge pclk);
    checkOutput("setup_psel",    64'(psel),      64'd1);
    checkOutput("setup_penable", 64'(penable),   64'd0);
    checkOutput("setup_paddr",   64'(paddr),     64'(addr));
    checkOutput("setup_pwrite",  64'(pwrite),    64'(wr));
    checkOutput("setup_ready",   64'(req_ready), 64'd0);
    if (wr) checkOutput("setup_pwdata", 64'(pwdata), 64'(wdata));
    for (int w = 0; w <= waits; w++) begin
      @(posedge pclk); #1;
      if (timeout) begin
        pready     = 1'b0;
        pslverr    = 1'b0;
        prdata_drv = 32'hFFFF_0000;
      end else begin
        pready     = (w == waits);
        pslverr    = (w == waits) ? slverr : 1'b1;
        prdata_drv = (w == waits) ? rdata : (32'hBAD0_0000 | 32'(w));
      end
      @(negedge pclk);
      checkOutput("access_psel",    64'(psel),      64'd1);
      checkOutput("access_penable", 64'(penable),   64'd1);
      checkOutput("access_paddr",   64'(paddr),     64'(addr));
      checkOutput("access_rspv",    64'(rsp_valid), 64'd0);
    end
    @(posedge pclk); #1;
    pready  = 1'b0;
    pslverr = 1'b0;
    @(negedge pclk);
    checkOutput("done_psel",    64'(psel),      64'd0);
    checkOutput("done_penable", 64'(penable),   64'd0);
    checkOutput("done_rspv",    64'(rsp_valid), 64'(oh));
    checkOutput("done_rdata",   64'(rsp_rdata), 64'(e.rdata));
    checkOutput("done_err",     64'(rsp_err),   64'(e.err));
  endtask

  // Directed sequence: reset, round-robin, write, wait-state read, slave
  // error, watchdog abort, reset during ACCESS.
  initial begin
    exp_t e;
    int   idx;
    presetn    = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    prdata_drv = '0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    slave_auto = 1'b0;
    #2;
    checkOutput("rst_psel",    64'(psel),      64'd0);
    checkOutput("rst_penable", 64'(penable),   64'd0);
    checkOutput("rst_pwrite",  64'(pwrite),    64'd0);
    checkOutput("rst_paddr",   64'(paddr),     64'd0);
    checkOutput("rst_pwdata",  64'(pwdata),    64'd0);
    checkOutput("rst_rspv",    64'(rsp_valid), 64'd0);
    checkOutput("rst_rdata",   64'(rsp_rdata), 64'd0);
    checkOutput("rst_err",     64'(rsp_err),   64'd0);
    checkOutput("rst_ready",   64'(req_ready), 64'd0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;

    $display("[TB] round-robin with all requesters valid");
    slave_auto = 1'b1;
    pready     = 1'b1;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h100 + 32'(4 * i);
    req_valid = '1;
    @(negedge pclk);
    for (int g = 0; g < 6; g++) begin
      idx = g % NR;
      checkOutput("rr_grant", 64'(req_ready), 64'(NR'(1) << idx));
      e.idx   = idx;
      e.rdata = (32'h100 + 32'(4 * idx)) ^ 32'hC0DE_0000;
      e.err   = 1'b0;
      expq.push_back(e);
      if (g == 5) begin
        @(posedge pclk); #1;
        req_valid = '0;
      end
      repeat (3) @(negedge pclk);
    end
    slave_auto = 1'b0;
    pready     = 1'b0;

    $display("[TB] zero-wait write from requester 0");
    applyStimulus(0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);

    $display("[TB] read with three wait states from requester 1");
    applyStimulus(1, 1'b0, 32'h24, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);

    $display("[TB] read with slave error, then a normal read");
    applyStimulus(2, 1'b0, 32'h30, 32'h0, 0, 32'h1234_5678, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 1, 32'h600D_F00D, 1'b0, 1'b0);

    $display("[TB] watchdog abort on a stuck slave");
    applyStimulus(1, 1'b0, 32'h50, 32'h0, TO - 1, 32'h0, 1'b0, 1'b1);

    $display("[TB] reset during ACCESS");
    req_write[0]       = 1'b0;
    req_addr[0 +: AW]  = 32'h70;
    req_valid[0]       = 1'b1;
    #1;
    checkOutput("rst6_ready", 64'(req_ready), 64'd1);
    @(posedge pclk); #1;
    req_valid[0] = 1'b0;
    @(negedge pclk);
    @(posedge pclk); #1;
    @(negedge pclk);
    checkOutput("rst6_in_access", 64'(penable), 64'd1);
    #2;
    presetn = 1'b0;
    #1;
    checkOutput("rst6_psel",    64'(psel),      64'd0);
    checkOutput("rst6_penable", 64'(penable),   64'd0);
    checkOutput("rst6_rspv",    64'(rsp_valid), 64'd0);
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    req_write[1]       = 1'b0;
    req_addr[AW +: AW] = 32'h84;
    req_valid[1]       = 1'b1;
    applyStimulus(0, 1'b0, 32'h80, 32'h0, 0, 32'h1111_2222, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 32'h84, 32'h0, 0, 32'h3333_4444, 1'b0, 1'b0);

    repeat (3) @(negedge pclk);
    checkOutput("sb_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
